// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor: request side from the controller,
// result and status side back from the subtractor.
interface serial_sub_if #(parameter int n = 8);
  logic         start;
  logic         borrowin;
  logic [n-1:0] Xin;
  logic [n-1:0] Yin;
  logic [n-1:0] D;
  logic         borrowout;
  logic         overflow;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output start, borrowin, Xin, Yin,
    input  D, borrowout, overflow, zero, busy, done
  );

  modport slave (
    input  start, borrowin, Xin, Yin,
    output D, borrowout, overflow, zero, busy, done
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial D = X - Y - borrowin, LSB first, one bit per cycle; done pulses n+1 cycles after capture.
// start is taken only in IDLE/DONE, so a start during SHIFT is dropped rather than queued.
module serial_sub #(
  parameter int n = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  serial_sub_if.slave bus
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [n-1:0]   r_xr;
  logic [n-1:0]   r_yr;
  logic [n-1:0]   r_res;
  logic [n-1:0]   r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_b;
  logic           r_xmsb;
  logic           r_ymsb;
  logic           r_bo;
  logic           r_ov;
  logic           r_zero;

  logic           w_x;
  logic           w_y;
  logic           w_d;
  logic           w_b_nxt;
  logic           w_last;
  logic           w_accept;
  logic [n-1:0]   w_res_nxt;

  assign w_x       = r_xr[0];
  assign w_y       = r_yr[0];
  assign w_d       = w_x ^ w_y ^ r_b;
  assign w_b_nxt   = (~w_x & w_y) | (~(w_x ^ w_y) & r_b);
  assign w_last    = (r_cnt == CW'(n - 1));
  assign w_accept  = bus.start && (r_state != SHIFT);
  // New bit enters at the MSB; after n shifts bit 0 of the result sits at bit 0.
  assign w_res_nxt = n'({w_d, r_res} >> 1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = bus.start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_xr   <= '0;
      r_yr   <= '0;
      r_res  <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_b    <= 1'b0;
      r_xmsb <= 1'b0;
      r_ymsb <= 1'b0;
      r_bo   <= 1'b0;
      r_ov   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_xr   <= bus.Xin;
      r_yr   <= bus.Yin;
      r_b    <= bus.borrowin;
      r_xmsb <= bus.Xin[n-1];
      r_ymsb <= bus.Yin[n-1];
      r_res  <= '0;
      r_cnt  <= '0;
    end else if (r_state == SHIFT) begin
      r_xr  <= r_xr >> 1;
      r_yr  <= r_yr >> 1;
      r_b   <= w_b_nxt;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + CW'(1);
      // Operand MSBs were saved at capture since the shift registers no longer hold them.
      if (w_last) begin
        r_d    <= w_res_nxt;
        r_bo   <= w_b_nxt;
        r_ov   <= (r_xmsb != r_ymsb) && (w_d != r_xmsb);
        r_zero <= (w_res_nxt == '0);
      end
    end
  end

  assign bus.D         = r_d;
  assign bus.borrowout = r_bo;
  assign bus.overflow  = r_ov;
  assign bus.zero      = r_zero;
  assign bus.busy      = (r_state == SHIFT);
  assign bus.done      = (r_state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboarded bench for serial_sub: directed n=8 cases plus random sweeps at n=1, 4 and 8.
module tb_serial_sub;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } res_t;

  logic clk;
  logic rst;
  logic sweep_go;
  int   sweep_done;
  int   n_chk;
  int   n_err;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int w, input logic [7:0] x, input logic [7:0] y, input logic b);
    res_t r;
    int   mask;
    int   t;
    mask = (1 << w) - 1;
    t    = int'(x) - int'(y) - int'(b);
    r.d  = 8'(t & mask);
    r.bo = (t < 0);
    r.ov = (x[w-1] != y[w-1]) && (r.d[w-1] != x[w-1]);
    r.z  = (r.d == 8'd0);
    return r;
  endfunction

  // Directed instance, n = 8.
  serial_sub_if #(.n(8)) bus8 ();
  serial_sub #(.n(8)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(bus8.slave));

  res_t q8[$];
  bit   pd8;

  always @(negedge clk) begin
    res_t e;
    if (bus8.done) begin
      chk("d8_done_expected", 32'(q8.size() > 0), 32'd1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("d8_D", 32'(bus8.D), 32'(e.d));
        chk("d8_borrowout", 32'(bus8.borrowout), 32'(e.bo));
        chk("d8_overflow", 32'(bus8.overflow), 32'(e.ov));
        chk("d8_zero", 32'(bus8.zero), 32'(e.z));
      end
      chk("d8_done_pulse_prev", 32'(pd8), 32'd0);
    end
    pd8 = bus8.done;
  end

  task automatic wait_q8(input string tag);
    for (int c = 0; c < 30 && q8.size() != 0; c++) @(negedge clk);
    chk({tag, "_done_seen"}, 32'(q8.size()), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic b, input logic [10:0] exp);
    @(negedge clk);
    bus8.Xin = x; bus8.Yin = y; bus8.borrowin = b; bus8.start = 1'b1;
    q8.push_back(model(8, x, y, b));
    @(negedge clk);
    bus8.start = 1'b0;
    wait_q8(tag);
    @(negedge clk);
    chk({tag, "_hold"}, 32'({bus8.D, bus8.borrowout, bus8.overflow, bus8.zero}), 32'(exp));
  endtask

  // Random sweep instances at n = 1, 4, 8.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int W = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    serial_sub_if #(.n(W)) bus ();
    serial_sub #(.n(W)) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

    res_t q[$];
    bit   pd;

    always @(negedge clk) begin
      res_t e;
      if (bus.done) begin
        chk($sformatf("sw%0d_done_expected", W), 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk($sformatf("sw%0d_D", W), 32'(bus.D), 32'(e.d));
          chk($sformatf("sw%0d_borrowout", W), 32'(bus.borrowout), 32'(e.bo));
          chk($sformatf("sw%0d_overflow", W), 32'(bus.overflow), 32'(e.ov));
          chk($sformatf("sw%0d_zero", W), 32'(bus.zero), 32'(e.z));
        end
        chk($sformatf("sw%0d_done_pulse_prev", W), 32'(pd), 32'd0);
      end
      pd = bus.done;
    end

    initial begin
      logic [7:0] x;
      logic [7:0] y;
      logic       b;
      bus.start = 1'b0; bus.borrowin = 1'b0; bus.Xin = '0; bus.Yin = '0;
      wait (sweep_go);
      for (int v = 0; v < 1000; v++) begin
        x = 8'($urandom & ((1 << W) - 1));
        y = 8'($urandom & ((1 << W) - 1));
        b = 1'($urandom);
        @(negedge clk);
        bus.Xin = x[W-1:0]; bus.Yin = y[W-1:0]; bus.borrowin = b; bus.start = 1'b1;
        q.push_back(model(W, x, y, b));
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < W + 6 && q.size() != 0; c++) @(negedge clk);
        chk($sformatf("sw%0d_done_seen", W), 32'(q.size()), 32'd0);
      end
      sweep_done++;
    end
  end

  initial begin
    int edges;
    int busy_n;
    bit seen;
    clk = 1'b0; rst = 1'b1; sweep_go = 1'b0; sweep_done = 0; n_chk = 0; n_err = 0;
    bus8.start = 1'b0; bus8.borrowin = 1'b0; bus8.Xin = '0; bus8.Yin = '0;
    #1;
    chk("reset_outputs", 32'({bus8.D, bus8.borrowout, bus8.overflow, bus8.zero, bus8.busy, bus8.done}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 100 - 58: latency and busy length measured from the capture edge.
    @(negedge clk);
    bus8.Xin = 8'd100; bus8.Yin = 8'd58; bus8.borrowin = 1'b0; bus8.start = 1'b1;
    q8.push_back(model(8, 8'd100, 8'd58, 1'b0));
    edges = 0; busy_n = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.busy) busy_n++;
      seen = bus8.done;
    end
    chk("t1_edges_to_done", 32'(edges), 32'd9);
    chk("t1_busy_cycles", 32'(busy_n), 32'd8);
    @(negedge clk);
    chk("t1_hold", 32'({bus8.D, bus8.borrowout, bus8.overflow, bus8.zero}), 32'({8'd42, 3'b000}));

    op8("t2_0m1",   8'h00, 8'h01, 1'b0, {8'hFF, 3'b100});
    op8("t2_0m0m1", 8'h00, 8'h00, 1'b1, {8'hFF, 3'b100});
    op8("t3_ovf",   8'h80, 8'h01, 1'b0, {8'h7F, 3'b010});
    op8("t3_zero",  8'h37, 8'h37, 1'b0, {8'h00, 3'b001});

    // start held through SHIFT, still high in DONE: next op starts with no idle cycle.
    @(negedge clk);
    bus8.Xin = 8'h10; bus8.Yin = 8'h05; bus8.borrowin = 1'b0; bus8.start = 1'b1;
    q8.push_back(model(8, 8'h10, 8'h05, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus8.Xin = 8'hC8; bus8.Yin = 8'h64;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t4_done_first", 32'(bus8.done), 32'd1);
    q8.push_back(model(8, 8'hC8, 8'h64, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    chk("t4_busy_no_gap", 32'(bus8.busy), 32'd1);
    chk("t4_done_one_cycle", 32'(bus8.done), 32'd0);
    bus8.Xin = 8'hFF; bus8.Yin = 8'hFF;
    wait_q8("t4_second");
    @(negedge clk);
    chk("t4_hold", 32'({bus8.D, bus8.borrowout, bus8.overflow, bus8.zero}), 32'({8'h64, 3'b010}));
    repeat (12) @(negedge clk);

    // Reset at cnt=4 of an operation: outputs clear at once, no completion follows.
    @(negedge clk);
    bus8.Xin = 8'hF0; bus8.Yin = 8'h0F; bus8.borrowin = 1'b0; bus8.start = 1'b1;
    q8.push_back(model(8, 8'hF0, 8'h0F, 1'b0));
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    q8.delete();
    #1;
    chk("t5_async_clear", 32'({bus8.D, bus8.borrowout, bus8.overflow, bus8.zero, bus8.busy, bus8.done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("t5_no_done_after_abort", 32'(pd8), 32'd0);
    op8("t5_after", 8'hF0, 8'h0F, 1'b0, {8'hE1, 3'b000});

    sweep_go = 1'b1;
    for (int c = 0; c < 20000 && sweep_done != 3; c++) @(negedge clk);
    chk("sweep_complete", 32'(sweep_done), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
